// File: rtl/modport_fetch.sv
// Instruction-fetch front end: drives a 1-cycle-latency instruction memory and hands
// registered {instr, pc, valid} to decode. Static JAL prediction; BTFN_PREDICT_EN adds backward branches.
module modport_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [31:0] addr,
    input  logic [31:0] data,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        valid_o,
    output logic        pred_taken_o
);

    localparam int unsigned XLEN = 32;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic            req_v;
    logic [XLEN-1:0] req_pc;

    logic [XLEN-1:0] j_imm_c;
    logic [XLEN-1:0] b_imm_c;
    logic            is_jal_c;
    logic            is_bwd_br_c;
    logic            pred_c;
    logic [XLEN-1:0] target_c;
    logic            unused_bits;

    assign j_imm_c  = {{11{data[31]}}, data[31], data[19:12], data[20], data[30:21], 1'b0};
    assign b_imm_c  = {{19{data[31]}}, data[31], data[7], data[30:25], data[11:8], 1'b0};
    assign is_jal_c = (data[6:0] == OPC_JAL);

`ifdef BTFN_PREDICT_EN
    // Backward conditional branches (negative offset) are predicted taken.
    assign is_bwd_br_c = (data[6:0] == OPC_BRANCH) && data[31];
`else
    assign is_bwd_br_c = 1'b0;
`endif

    assign pred_c   = req_v && (is_jal_c || is_bwd_br_c);
    assign target_c = (req_pc + (is_jal_c ? j_imm_c : b_imm_c)) & ~XLEN'(3);

    assign unused_bits = ^{redirect_pc_i[1:0], b_imm_c[0], OPC_BRANCH};

    // Fetch address, in-flight request tracking and decode-facing output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr         <= RESET_PC;
            req_v        <= 1'b0;
            req_pc       <= '0;
            valid_o      <= 1'b0;
            instr_o      <= NOP_INSTR;
            pc_o         <= '0;
            pred_taken_o <= 1'b0;
        end else if (redirect_i) begin
            addr         <= {redirect_pc_i[XLEN-1:2], 2'b00};
            req_v        <= 1'b0;
            valid_o      <= 1'b0;
            instr_o      <= NOP_INSTR;
            pred_taken_o <= 1'b0;
        end else if (stall_i) begin
            // Drop the in-flight word and rewind so it is fetched again after the stall.
            if (req_v) begin
                addr <= req_pc;
            end
            req_v <= 1'b0;
        end else begin
            valid_o <= req_v;
            if (req_v) begin
                instr_o <= data;
                pc_o    <= req_pc;
            end else begin
                instr_o <= NOP_INSTR;
            end
            if (pred_c) begin
                addr         <= target_c;
                req_v        <= 1'b0;
                pred_taken_o <= 1'b1;
            end else begin
                req_v        <= 1'b1;
                req_pc       <= addr;
                addr         <= addr + XLEN'(4);
                pred_taken_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_modport_fetch.sv
// Directed self-checking bench for modport_fetch with a 1-cycle-latency instruction memory model.
// Expectations for the branch case follow BTFN_PREDICT_EN.
module tb_modport_fetch;

    logic        clock;
    logic        reset_n;
    logic [31:0] addr;
    logic [31:0] data;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        valid_o;
    logic        pred_taken_o;

    int n_checks;
    int n_fails;

    logic [31:0] mem [0:127];
    logic [31:0] mem_a;

    modport_fetch dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .addr         (addr),
        .data         (data),
        .stall_i      (stall_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .instr_o      (instr_o),
        .pc_o         (pc_o),
        .valid_o      (valid_o),
        .pred_taken_o (pred_taken_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous memory: word for the address seen at the edge appears 1ns later.
    always @(posedge clock) begin
        mem_a = addr;
        #1 data = mem[mem_a[8:2]];
    end

    // addi x0,x0,k : unique, never a jump or branch.
    function automatic logic [31:0] addi_word(input int unsigned k);
        return 32'h0000_0013 | (32'(k) << 20);
    endfunction

    function automatic logic [31:0] w_at(input logic [31:0] a);
        return mem[a[8:2]];
    endfunction

    task automatic init_mem();
        for (int i = 0; i < 128; i++) mem[i] = addi_word(32'(i));
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [31:0] pc,
                              input logic [31:0] ins, input logic pt);
        check({tag, ".valid"}, 32'(valid_o), 32'(v));
        if (v) check({tag, ".pc"}, pc_o, pc);
        check({tag, ".instr"}, instr_o, ins);
        check({tag, ".pred"}, 32'(pred_taken_o), 32'(pt));
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        repeat (3) tick();
        check("rst.addr", addr, 32'h0);
        check("rst.valid", 32'(valid_o), 32'h0);
        check("rst.instr", instr_o, 32'h13);
        check("rst.pc", pc_o, 32'h0);
        check("rst.pred", 32'(pred_taken_o), 32'h0);
        reset_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset_n  = 1'b0;

        // Sequential fetch
        init_mem();
        do_reset();
        tick(); check("seq.addr1", addr, 32'h4); expect_out("seq.e1", 1'b0, 32'h0, 32'h13, 1'b0);
        tick(); expect_out("seq.pc0", 1'b1, 32'h0, addi_word(0), 1'b0); check("seq.addr2", addr, 32'h8);
        tick(); expect_out("seq.pc4", 1'b1, 32'h4, addi_word(1), 1'b0);
        tick(); expect_out("seq.pc8", 1'b1, 32'h8, addi_word(2), 1'b0);
        tick(); expect_out("seq.pcC", 1'b1, 32'hC, addi_word(3), 1'b0);

        // JAL +16 at address 8
        init_mem();
        mem[2] = 32'h0100_006F;
        do_reset();
        tick();
        tick(); expect_out("jal.pc0", 1'b1, 32'h0, addi_word(0), 1'b0);
        tick(); expect_out("jal.pc4", 1'b1, 32'h4, addi_word(1), 1'b0);
        tick(); expect_out("jal.pc8", 1'b1, 32'h8, 32'h0100_006F, 1'b1); check("jal.addr", addr, 32'h18);
        tick(); expect_out("jal.bubble", 1'b0, 32'h0, 32'h13, 1'b0);
        tick(); expect_out("jal.pc24", 1'b1, 32'h18, addi_word(6), 1'b0);

        // Stall for three edges while pc_o=4
        init_mem();
        do_reset();
        tick(); tick(); tick();
        expect_out("stl.pre", 1'b1, 32'h4, addi_word(1), 1'b0);
        stall_i = 1'b1;
        tick(); expect_out("stl.h1", 1'b1, 32'h4, addi_word(1), 1'b0); check("stl.addr1", addr, 32'h8);
        tick(); expect_out("stl.h2", 1'b1, 32'h4, addi_word(1), 1'b0); check("stl.addr2", addr, 32'h8);
        tick(); expect_out("stl.h3", 1'b1, 32'h4, addi_word(1), 1'b0); check("stl.addr3", addr, 32'h8);
        stall_i = 1'b0;
        tick(); expect_out("stl.bubble", 1'b0, 32'h0, 32'h13, 1'b0);
        tick(); expect_out("stl.pc8", 1'b1, 32'h8, addi_word(2), 1'b0);
        tick(); expect_out("stl.pcC", 1'b1, 32'hC, addi_word(3), 1'b0);

        // Redirect wins over a simultaneous stall; low address bits are dropped
        init_mem();
        do_reset();
        tick(); tick(); tick();
        stall_i       = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0103;
        tick(); check("rdr.addr", addr, 32'h100); expect_out("rdr.e1", 1'b0, 32'h0, 32'h13, 1'b0);
        stall_i    = 1'b0;
        redirect_i = 1'b0;
        tick(); expect_out("rdr.e2", 1'b0, 32'h0, 32'h13, 1'b0);
        tick(); expect_out("rdr.pc100", 1'b1, 32'h100, w_at(32'h100), 1'b0);

        // Address wrap from the top of the space
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFF;
        tick(); check("wrap.addr0", addr, 32'hFFFF_FFFC);
        redirect_i = 1'b0;
        tick(); check("wrap.addr1", addr, 32'h0);
        tick(); expect_out("wrap.pc", 1'b1, 32'hFFFF_FFFC, w_at(32'hFFFF_FFFC), 1'b0);
        check("wrap.addr2", addr, 32'h4);

        // Backward BEQ -8 at address 20
        init_mem();
        mem[5] = 32'hFE00_0CE3;
        do_reset();
        repeat (6) tick();
        expect_out("br.pc16", 1'b1, 32'h10, addi_word(4), 1'b0);
        tick();
`ifdef BTFN_PREDICT_EN
        expect_out("br.pc20", 1'b1, 32'h14, 32'hFE00_0CE3, 1'b1);
        tick(); expect_out("br.bubble", 1'b0, 32'h0, 32'h13, 1'b0);
        tick(); expect_out("br.pc12", 1'b1, 32'hC, addi_word(3), 1'b0);
`else
        expect_out("br.pc20", 1'b1, 32'h14, 32'hFE00_0CE3, 1'b0);
        tick(); expect_out("br.pc24", 1'b1, 32'h18, addi_word(6), 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
